fetch_memory_bridge: RTL and testbench
======================================

# fetch_memory_bridge

Instruction-bus bridge between the fetch stage and a pipelined, Avalon-style instruction memory. It turns fetch's per-cycle `address_enable`/`address` request into single-outstanding memory reads. It returns the word to fetch as `data`/`data_valid` and keeps the last returned word in a one-entry buffer, so a stalled fetch does not lose it. On a PC change it discards in-flight responses and reports `has_flushed` once the bus is quiet.

## Interface
- `MAX_WAIT`, default 255: cycles a request may stay outstanding before it is abandoned and `bus_error` is set; range 2..65535.
- `clock` input, 1 bit: single clock; all state updates on its rising edge.
- `reset_n` input, 1 bit: reset, asynchronous, active-low.
- `address_enable` input, 1 bit: fetch requests the word at `address` this cycle.
- `address` input, regval_t (32 bits): byte address of the requested instruction.
- `flush` input, 1 bit: PC is changing this cycle (driven from fetch's `is_pc_changing`).
- `data` output, regval_t: instruction word; 0 when `data_valid`=0.
- `data_valid` output, 1 bit: `data` is the word at `address` this cycle.
- `has_flushed` output, 1 bit: no memory read outstanding.
- `mem_read` output, 1 bit: read command to memory.
- `mem_address` output, 32 bits: word-aligned read address.
- `mem_waitrequest` input, 1 bit: memory has not accepted the command.
- `mem_readdata` input, 32 bits: read response data.
- `mem_readdatavalid` input, 1 bit: `mem_readdata` is valid.
- `bus_error` output, 1 bit: sticky timeout flag.

## Operation
- Registered state: `state` ∈ {Idle, Request, Wait, Stale}, `req_addr`, `buf_valid`, `buf_addr`, `buf_data`, `wait_count`, `bus_error`.
- Hit: `address_enable` && `buf_valid` && `buf_addr[31:2]` == `address[31:2]`.
- Forward: `state`==Wait && `mem_readdatavalid` && !`flush` && `address_enable` && `req_addr[31:2]`==`address[31:2]`.
- `data_valid` = !`flush` && (forward || hit). On forward, `data` = `mem_readdata`; else on hit, `data` = `buf_data`; else `data` = 0. Forward has priority over hit.
- Idle:
  - If `address_enable` && !hit && !`flush`: `req_addr` <= `address`, go to Request.
  - Otherwise stay in Idle.
- Request:
  - `mem_read`=1 and `mem_address` = {`req_addr[31:2]`, 2'b00}.
  - On !`mem_waitrequest`, go to Wait, or to Stale if `flush` is high this cycle.
  - A `flush` while `mem_waitrequest`=1 does not drop `mem_read`. The command completes, then goes to Stale.
  - Track this with a `stale_pending` bit that is set by `flush` in Request and cleared on leaving Request.
- Wait:
  - If `flush` is high: go to Stale, or to Idle if `mem_readdatavalid` is also high (the response is discarded).
  - Else, on `mem_readdatavalid`: `buf_addr` <= `req_addr`, `buf_data` <= `mem_readdata`, `buf_valid` <= 1, go to Idle.
- Stale: on `mem_readdatavalid`, discard the response and go to Idle.
- `flush` in any state clears `buf_valid`.
- `mem_readdatavalid` in Idle or Request is ignored.
- `has_flushed` = (`state`==Idle).
- Timeout:
  - `wait_count` resets to 0 on entering Request and increments each cycle in Request, Wait or Stale.
  - When it reaches `MAX_WAIT`: `bus_error` <= 1, go to Idle, `mem_read` deasserts.
  - `bus_error` is cleared only by reset.
- Reset values: `state` Idle, `mem_read` 0, `mem_address` 0, `buf_valid` 0, `buf_addr` 0, `buf_data` 0, `wait_count` 0, `bus_error` 0. While `reset_n`=0: `data_valid` 0, `data` 0, `has_flushed` 1.

## Timing
- Miss latency with a zero-wait memory:
  - Cycle N: Idle with `address_enable`.
  - Cycle N+1: `mem_read`=1 and accepted.
  - Cycle N+2: `mem_readdatavalid`; the word is forwarded combinationally with `data_valid`=1.
  - Cycle N+3: Idle; the next address is requested.
- Sustained rate is one word per 3 cycles. Each `mem_waitrequest` cycle or response-delay cycle adds one cycle.
- A hit returns `data_valid` in the same cycle as `address_enable`, with no memory traffic.
- At most one read is outstanding at any time.
- `data_valid` is purely combinational from the current inputs and registered state. There is no path from `data_valid` back to `mem_read`.
- Reset asserted mid-request abandons the request immediately. A late `mem_readdatavalid` after reset arrives in Idle and is ignored.

## Test plan
- Reset, then `address`=0x0000_0100 with `address_enable` held and a zero-wait memory returning 0x1234_5678 → `mem_read` in cycle 1 with `mem_address`=0x100; `data_valid`=1 and `data`=0x1234_5678 in cycle 2; `has_flushed`=1 in cycle 3.
- Same as above, but `address_enable` drops in cycle 2 (hold) and returns in cycle 5 → buffer hit in cycle 5 with `data`=0x1234_5678 and no new `mem_read`.
- `flush` pulses in cycle 1 while `mem_waitrequest`=1 for 3 cycles → `mem_read` stays high until accepted; the state then goes to Stale; the response is discarded with `data_valid`=0; `has_flushed`=0 until the cycle after `mem_readdatavalid`.
- `flush` in the same cycle as `mem_readdatavalid` → `data_valid`=0, `buf_valid`=0, state goes to Idle next cycle.
- `MAX_WAIT`=4 and a memory that never responds → `bus_error`=1 after 4 cycles outstanding; `mem_read`=0 and state Idle thereafter; `bus_error` clears only after `reset_n` pulses low.
- Unaligned `address`=0x0000_0203 → `mem_address`=0x0000_0200; a subsequent request to 0x200 is a buffer hit.

Source files
------------

// File: rtl/fetch_memory_bridge.sv
// Fetch-to-instruction-memory bridge: single-outstanding Avalon-style reads,
// a one-word return buffer, flush-aware response discard and a bus timeout.
module fetch_memory_bridge #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        address_enable,
  input  logic [31:0] address,
  input  logic        flush,
  output logic [31:0] data,
  output logic        data_valid,
  output logic        has_flushed,
  output logic        mem_read,
  output logic [31:0] mem_address,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata,
  input  logic        mem_readdatavalid,
  output logic        bus_error
);

  // state   | meaning
  // IDLE    | no read outstanding; buffer hits served, misses start a read
  // REQUEST | mem_read asserted, waiting for the command to be accepted
  // WAIT    | command accepted, response will be forwarded and buffered
  // STALE   | command accepted but flushed; response will be discarded
  typedef enum logic [1:0] {IDLE, REQUEST, WAIT, STALE} state_t;

  localparam logic [15:0] WAIT_LIMIT = 16'(MAX_WAIT);

  state_t      state;
  logic [31:0] req_addr;
  logic [31:0] buf_addr;
  logic [31:0] buf_data;
  logic        buf_valid;
  logic        stale_pending;
  logic [15:0] wait_count;
  logic [15:0] wait_next;
  logic        timeout;
  logic        hit;
  logic        forward;

  assign wait_next = wait_count + 16'd1;
  assign timeout   = (wait_next == WAIT_LIMIT);

  assign hit     = address_enable && buf_valid && (buf_addr[31:2] == address[31:2]);
  assign forward = (state == WAIT) && mem_readdatavalid && !flush && address_enable &&
                   (req_addr[31:2] == address[31:2]);

  always_comb begin
    data_valid = !flush && (forward || hit);
    data       = 32'd0;
    if (data_valid) data = forward ? mem_readdata : buf_data;
  end

  assign has_flushed = (state == IDLE);
  assign mem_read    = (state == REQUEST);
  assign mem_address = {req_addr[31:2], 2'b00};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      req_addr      <= 32'd0;
      buf_addr      <= 32'd0;
      buf_data      <= 32'd0;
      buf_valid     <= 1'b0;
      stale_pending <= 1'b0;
      wait_count    <= 16'd0;
      bus_error     <= 1'b0;
    end else begin
      if (flush) buf_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (address_enable && !hit && !flush) begin
            req_addr      <= address;
            wait_count    <= 16'd0;
            stale_pending <= 1'b0;
            state         <= REQUEST;
          end
        end
        REQUEST: begin
          wait_count <= wait_next;
          if (flush) stale_pending <= 1'b1;
          // Timeout wins over a same-cycle accept so the counter never overshoots.
          if (timeout) begin
            bus_error     <= 1'b1;
            stale_pending <= 1'b0;
            state         <= IDLE;
          end else if (!mem_waitrequest) begin
            stale_pending <= 1'b0;
            state         <= (flush || stale_pending) ? STALE : WAIT;
          end
        end
        WAIT: begin
          wait_count <= wait_next;
          if (mem_readdatavalid) begin
            if (!flush) begin
              buf_addr  <= req_addr;
              buf_data  <= mem_readdata;
              buf_valid <= 1'b1;
            end
            state <= IDLE;
          end else if (timeout) begin
            bus_error <= 1'b1;
            state     <= IDLE;
          end else if (flush) begin
            state <= STALE;
          end
        end
        STALE: begin
          wait_count <= wait_next;
          if (mem_readdatavalid) begin
            state <= IDLE;
          end else if (timeout) begin
            bus_error <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_memory_bridge.sv
// Directed bench for fetch_memory_bridge: a default-timeout instance for the
// data path and flush cases, and a MAX_WAIT=4 instance for the timeout case.
module tb_fetch_memory_bridge;

  logic        clock;
  logic        reset_n;
  logic        address_enable;
  logic [31:0] address;
  logic        flush;
  logic [31:0] data;
  logic        data_valid;
  logic        has_flushed;
  logic        mem_read;
  logic [31:0] mem_address;
  logic        mem_waitrequest;
  logic [31:0] mem_readdata;
  logic        mem_readdatavalid;
  logic        bus_error;

  logic        t_enable;
  logic [31:0] t_address;
  logic        t_flush;
  logic [31:0] t_data;
  logic        t_data_valid;
  logic        t_has_flushed;
  logic        t_mem_read;
  logic [31:0] t_mem_address;
  logic        t_waitrequest;
  logic [31:0] t_readdata;
  logic        t_readdatavalid;
  logic        t_bus_error;

  int errors = 0;
  int checks = 0;

  fetch_memory_bridge dut (
    .clock(clock), .reset_n(reset_n),
    .address_enable(address_enable), .address(address), .flush(flush),
    .data(data), .data_valid(data_valid), .has_flushed(has_flushed),
    .mem_read(mem_read), .mem_address(mem_address),
    .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
    .mem_readdatavalid(mem_readdatavalid), .bus_error(bus_error)
  );

  fetch_memory_bridge #(.MAX_WAIT(4)) dut_to (
    .clock(clock), .reset_n(reset_n),
    .address_enable(t_enable), .address(t_address), .flush(t_flush),
    .data(t_data), .data_valid(t_data_valid), .has_flushed(t_has_flushed),
    .mem_read(t_mem_read), .mem_address(t_mem_address),
    .mem_waitrequest(t_waitrequest), .mem_readdata(t_readdata),
    .mem_readdatavalid(t_readdatavalid), .bus_error(t_bus_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 4 units later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic en, input logic [31:0] addr, input logic fl,
                       input logic wr, input logic rdv, input logic [31:0] rd);
    address_enable    = en;
    address           = addr;
    flush             = fl;
    mem_waitrequest   = wr;
    mem_readdatavalid = rdv;
    mem_readdata      = rd;
    #4;
  endtask

  initial begin
    reset_n = 1'b0;
    address_enable = 0; address = 0; flush = 0;
    mem_waitrequest = 0; mem_readdata = 0; mem_readdatavalid = 0;
    t_enable = 0; t_address = 0; t_flush = 0;
    t_waitrequest = 0; t_readdata = 0; t_readdatavalid = 0;

    tick(); tick();
    #4;
    check("rst_has_flushed", {31'd0, has_flushed}, 32'd1);
    check("rst_data_valid", {31'd0, data_valid}, 32'd0);
    check("rst_data", data, 32'd0);
    check("rst_mem_read", {31'd0, mem_read}, 32'd0);
    check("rst_mem_address", mem_address, 32'd0);
    check("rst_bus_error", {31'd0, bus_error}, 32'd0);

    // Zero-wait miss, forward, then buffer hits
    tick(); reset_n = 1'b1;
    drive(1, 32'h100, 0, 0, 0, 0);
    check("miss_c0_mem_read", {31'd0, mem_read}, 32'd0);
    check("miss_c0_dv", {31'd0, data_valid}, 32'd0);
    tick(); drive(1, 32'h100, 0, 0, 0, 0);
    check("miss_c1_mem_read", {31'd0, mem_read}, 32'd1);
    check("miss_c1_mem_address", mem_address, 32'h100);
    check("miss_c1_has_flushed", {31'd0, has_flushed}, 32'd0);
    tick(); drive(1, 32'h100, 0, 0, 1, 32'h1234_5678);
    check("miss_c2_dv", {31'd0, data_valid}, 32'd1);
    check("miss_c2_data", data, 32'h1234_5678);
    tick(); drive(0, 32'h100, 0, 0, 0, 0);
    check("miss_c3_has_flushed", {31'd0, has_flushed}, 32'd1);
    check("miss_c3_mem_read", {31'd0, mem_read}, 32'd0);
    tick(); drive(0, 32'h100, 0, 0, 0, 0);
    check("hold_c4_dv", {31'd0, data_valid}, 32'd0);
    check("hold_c4_data", data, 32'd0);
    tick(); drive(1, 32'h100, 0, 0, 0, 0);
    check("hit_c5_dv", {31'd0, data_valid}, 32'd1);
    check("hit_c5_data", data, 32'h1234_5678);
    tick(); drive(1, 32'h100, 0, 0, 0, 0);
    check("hit_c6_no_mem_read", {31'd0, mem_read}, 32'd0);
    check("hit_c6_has_flushed", {31'd0, has_flushed}, 32'd1);

    // Flush while command is held off by waitrequest
    tick(); drive(1, 32'h300, 0, 0, 0, 0);
    check("fwr_c0_dv", {31'd0, data_valid}, 32'd0);
    tick(); drive(1, 32'h300, 1, 1, 0, 0);
    check("fwr_c1_mem_read", {31'd0, mem_read}, 32'd1);
    check("fwr_c1_dv", {31'd0, data_valid}, 32'd0);
    tick(); drive(1, 32'h300, 0, 1, 0, 0);
    check("fwr_c2_mem_read", {31'd0, mem_read}, 32'd1);
    tick(); drive(1, 32'h300, 0, 1, 0, 0);
    check("fwr_c3_mem_read", {31'd0, mem_read}, 32'd1);
    tick(); drive(1, 32'h300, 0, 0, 0, 0);
    check("fwr_c4_mem_read", {31'd0, mem_read}, 32'd1);
    tick(); drive(1, 32'h300, 0, 0, 0, 0);
    check("fwr_c5_mem_read", {31'd0, mem_read}, 32'd0);
    check("fwr_c5_has_flushed", {31'd0, has_flushed}, 32'd0);
    tick(); drive(1, 32'h300, 0, 0, 1, 32'hDEAD_BEEF);
    check("fwr_c6_stale_dv", {31'd0, data_valid}, 32'd0);
    check("fwr_c6_stale_data", data, 32'd0);
    check("fwr_c6_has_flushed", {31'd0, has_flushed}, 32'd0);
    tick(); drive(1, 32'h100, 0, 0, 0, 0);
    check("fwr_c7_has_flushed", {31'd0, has_flushed}, 32'd1);
    check("fwr_c7_buf_cleared", {31'd0, data_valid}, 32'd0);

    // Flush coinciding with the response
    tick(); drive(1, 32'h100, 0, 0, 0, 0);
    check("frdv_c8_mem_read", {31'd0, mem_read}, 32'd1);
    check("frdv_c8_mem_address", mem_address, 32'h100);
    tick(); drive(1, 32'h100, 1, 0, 1, 32'hCAFE_F00D);
    check("frdv_c9_dv", {31'd0, data_valid}, 32'd0);
    check("frdv_c9_data", data, 32'd0);
    tick(); drive(0, 32'h100, 0, 0, 0, 0);
    check("frdv_c10_has_flushed", {31'd0, has_flushed}, 32'd1);
    check("frdv_c10_mem_read", {31'd0, mem_read}, 32'd0);
    tick(); drive(1, 32'h100, 0, 0, 0, 0);
    check("frdv_c11_not_buffered", {31'd0, data_valid}, 32'd0);
    tick(); drive(1, 32'h100, 0, 0, 0, 0);
    check("frdv_c12_mem_read", {31'd0, mem_read}, 32'd1);
    tick(); drive(1, 32'h100, 0, 0, 1, 32'h0BAD_C0DE);
    check("frdv_c13_fwd_data", data, 32'h0BAD_C0DE);
    tick(); drive(0, 32'h0, 0, 0, 0, 0);

    // Unaligned request, then aligned hit on the same word
    tick(); drive(1, 32'h203, 0, 0, 0, 0);
    tick(); drive(1, 32'h203, 0, 0, 0, 0);
    check("unal_mem_address", mem_address, 32'h200);
    check("unal_mem_read", {31'd0, mem_read}, 32'd1);
    tick(); drive(1, 32'h203, 0, 0, 1, 32'h55AA_55AA);
    check("unal_fwd_data", data, 32'h55AA_55AA);
    tick(); drive(1, 32'h200, 0, 0, 0, 0);
    check("unal_hit_dv", {31'd0, data_valid}, 32'd1);
    check("unal_hit_data", data, 32'h55AA_55AA);
    tick(); drive(0, 32'h200, 0, 0, 0, 0);
    check("unal_no_mem_read", {31'd0, mem_read}, 32'd0);

    // Timeout on the MAX_WAIT=4 instance with a memory that never responds
    tick(); t_enable = 1; t_address = 32'h400; #4;
    check("to_c0_has_flushed", {31'd0, t_has_flushed}, 32'd1);
    tick(); #4;
    check("to_c1_mem_read", {31'd0, t_mem_read}, 32'd1);
    tick(); #4;
    check("to_c2_has_flushed", {31'd0, t_has_flushed}, 32'd0);
    tick(); #4;
    check("to_c3_bus_error", {31'd0, t_bus_error}, 32'd0);
    tick(); #4;
    check("to_c4_bus_error", {31'd0, t_bus_error}, 32'd0);
    check("to_c4_has_flushed", {31'd0, t_has_flushed}, 32'd0);
    tick(); t_enable = 0; #4;
    check("to_c5_bus_error", {31'd0, t_bus_error}, 32'd1);
    check("to_c5_mem_read", {31'd0, t_mem_read}, 32'd0);
    check("to_c5_has_flushed", {31'd0, t_has_flushed}, 32'd1);
    tick(); t_readdatavalid = 1; t_readdata = 32'h77; #4;
    check("to_c6_late_dv", {31'd0, t_data_valid}, 32'd0);
    check("to_c6_bus_error", {31'd0, t_bus_error}, 32'd1);
    tick(); t_readdatavalid = 0; #4;
    check("to_c7_has_flushed", {31'd0, t_has_flushed}, 32'd1);
    check("to_c7_bus_error_sticky", {31'd0, t_bus_error}, 32'd1);

    // Reset asserted mid-request
    tick(); drive(1, 32'h600, 0, 0, 0, 0);
    tick(); drive(1, 32'h600, 0, 0, 0, 0);
    check("mrst_mem_read_before", {31'd0, mem_read}, 32'd1);
    #2; reset_n = 1'b0; address_enable = 0; #1;
    check("mrst_mem_read", {31'd0, mem_read}, 32'd0);
    check("mrst_has_flushed", {31'd0, has_flushed}, 32'd1);
    check("mrst_bus_error_cleared", {31'd0, t_bus_error}, 32'd0);
    tick(); tick(); reset_n = 1'b1;
    drive(0, 32'h600, 0, 0, 1, 32'h9999_9999);
    check("mrst_late_dv", {31'd0, data_valid}, 32'd0);
    check("mrst_late_has_flushed", {31'd0, has_flushed}, 32'd1);
    tick(); drive(0, 32'h600, 0, 0, 0, 0);
    check("mrst_idle_mem_read", {31'd0, mem_read}, 32'd0);
    check("mrst_bus_error_stays", {31'd0, t_bus_error}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
